// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: next-PC operation
// encodings, reset/instruction-memory address constants, the NOP word
// and the branch offset helper.
package mips_pkg;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_J      = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_VAL  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP_VAL   = 32'h0000_6FFC;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fd_if.sv
// Fetch/decode boundary signals between the hazard unit, decode stage,
// instruction memory and ifu_fd. The D_excAdEL signal exists only when
// IFU_FD_ADEL_EN is defined.
interface ifu_fd_if;

    logic        stall;
    logic [1:0]  D_npcOp;
    logic        D_branchTaken;
    logic [31:0] D_rsData;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
`ifdef IFU_FD_ADEL_EN
    logic        D_excAdEL;

    modport master (
        output stall, D_npcOp, D_branchTaken, D_rsData, F_instr,
        input  F_pc, D_instr, D_pc, D_excAdEL
    );

    modport slave (
        input  stall, D_npcOp, D_branchTaken, D_rsData, F_instr,
        output F_pc, D_instr, D_pc, D_excAdEL
    );
`else
    modport master (
        output stall, D_npcOp, D_branchTaken, D_rsData, F_instr,
        input  F_pc, D_instr, D_pc
    );

    modport slave (
        input  stall, D_npcOp, D_branchTaken, D_rsData, F_instr,
        output F_pc, D_instr, D_pc
    );
`endif

endinterface

// File: rtl/npc.sv
// Next-PC selection. Purely combinational; branch and jump targets are
// formed from the instruction held in D, never from the one being fetched.
module npc
    import mips_pkg::*;
(
    input  logic [31:0] F_pc,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [1:0]  D_npcOp,
    input  logic        D_branchTaken,
    input  logic [31:0] D_rsData,
    output logic [31:0] npc_next
);

    logic [31:0] w_f_pc4;
    logic [31:0] w_d_pc4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_unused_opcode;

    assign w_f_pc4     = F_pc + 32'd4;
    assign w_d_pc4     = D_pc + 32'd4;
    assign w_br_target = w_d_pc4 + branch_offset(D_instr[15:0]);
    assign w_j_target  = {D_pc[31:28], D_instr[25:0], 2'b00};

    // Opcode field is decoded elsewhere; the operation arrives on D_npcOp.
    assign w_unused_opcode = ^D_instr[31:26];

    // Select the next fetch address from the decode-stage decision.
    always_comb begin
        npc_next = w_f_pc4;
        case (npc_op_e'(D_npcOp))
            NPC_PC4:    npc_next = w_f_pc4;
            NPC_BRANCH: npc_next = D_branchTaken ? w_br_target : w_f_pc4;
            NPC_J:      npc_next = w_j_target;
            NPC_JR:     npc_next = D_rsData;
            default:    npc_next = w_f_pc4;
        endcase
    end

endmodule

// File: rtl/ifu_fd.sv
// Instruction fetch unit with the F/D pipeline register. Holds the PC,
// advances it via npc, and latches the fetched word into D. The instruction
// in F is an architectural delay slot, so nothing is ever flushed.
// Optional fetch address-error detection: define IFU_FD_ADEL_EN.
module ifu_fd
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_VAL,
    parameter logic [31:0] IM_BASE  = IM_BASE_VAL,
    parameter logic [31:0] IM_TOP   = IM_TOP_VAL
)
(
    input  logic      clk,
    input  logic      reset,
    ifu_fd_if.slave   fd
);

    logic [31:0] r_pc;
    logic [31:0] r_d_instr;
    logic [31:0] r_d_pc;
    logic [31:0] w_npc;
    logic [31:0] w_fd_instr;

    npc u_npc (
        .F_pc          (r_pc),
        .D_pc          (r_d_pc),
        .D_instr       (r_d_instr),
        .D_npcOp       (fd.D_npcOp),
        .D_branchTaken (fd.D_branchTaken),
        .D_rsData      (fd.D_rsData),
        .npc_next      (w_npc)
    );

`ifdef IFU_FD_ADEL_EN
    logic r_d_adel;
    logic w_adel;

    assign w_adel     = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_TOP);
    // A faulting fetch is replaced by a NOP; the flag travels alongside it.
    assign w_fd_instr = w_adel ? NOP : fd.F_instr;

    // Address-error flag follows the F/D register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_adel <= 1'b0;
        end else if (!fd.stall) begin
            r_d_adel <= w_adel;
        end
    end

    assign fd.D_excAdEL = r_d_adel;
`else
    logic w_unused_bounds;

    assign w_unused_bounds = ^{IM_BASE, IM_TOP};
    assign w_fd_instr      = fd.F_instr;
`endif

    // Program counter: reset dominates stall, stall freezes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else if (!fd.stall) begin
            r_pc <= w_npc;
        end
    end

    // F/D pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_instr <= NOP;
            r_d_pc    <= '0;
        end else if (!fd.stall) begin
            r_d_instr <= w_fd_instr;
            r_d_pc    <= r_pc;
        end
    end

    assign fd.F_pc    = r_pc;
    assign fd.D_instr = r_d_instr;
    assign fd.D_pc    = r_d_pc;

endmodule

// File: tb/tb_ifu_fd.sv
// Self-checking bench for ifu_fd. Each cycle's expected outputs are queued
// as stimulus is driven; observed outputs are queued after the edge, and
// every test task drains and compares both queues.
module tb_ifu_fd;
    import mips_pkg::*;

`ifdef IFU_FD_ADEL_EN
    localparam bit ADEL_ON = 1'b1;
`else
    localparam bit ADEL_ON = 1'b0;
`endif

    localparam logic [31:0] I0   = 32'h2408_0001;
    localparam logic [31:0] I1   = 32'h2409_0002;
    localparam logic [31:0] I2   = 32'h240A_0003;
    localparam logic [31:0] BEQ  = 32'h1000_FFFC;
    localparam logic [31:0] BEQF = 32'h1000_0010;
    localparam logic [31:0] DS   = 32'h014B_6020;
    localparam logic [31:0] JI   = 32'h0800_0C40;
    localparam logic [31:0] JRI  = 32'h03E0_0008;

    typedef struct {
        logic [31:0] fpc;
        logic [31:0] dinstr;
        logic [31:0] dpc;
        logic        adel;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    always #5 clk = ~clk;

    ifu_fd_if bus();

    ifu_fd #(
        .PC_RESET (32'h0000_3000),
        .IM_BASE  (32'h0000_3000),
        .IM_TOP   (32'h0000_6FFC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fd    (bus)
    );

    // Drive one cycle of inputs, queue the expectation, clock, queue what was seen.
    task automatic drive_cycle(input bit rst, input bit st, input logic [1:0] op,
                               input bit tk, input logic [31:0] rs, input logic [31:0] fi,
                               input logic [31:0] e_fpc, input logic [31:0] e_di,
                               input logic [31:0] e_dpc, input bit e_adel);
        obs_t e, o;
        reset             = rst;
        bus.stall         = st;
        bus.D_npcOp       = op;
        bus.D_branchTaken = tk;
        bus.D_rsData      = rs;
        bus.F_instr       = fi;
        e.fpc = e_fpc; e.dinstr = e_di; e.dpc = e_dpc; e.adel = e_adel;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.fpc    = bus.F_pc;
        o.dinstr = bus.D_instr;
        o.dpc    = bus.D_pc;
`ifdef IFU_FD_ADEL_EN
        o.adel   = bus.D_excAdEL;
`else
        o.adel   = 1'b0;
`endif
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        obs_t e, o;
        int   n = 0;
        drive_cycle(1, 0, 2'b00, 0, 32'h0, I0, 32'h3000, NOP, 32'h0, 0);
        drive_cycle(1, 0, 2'b11, 1, 32'h5555, I1, 32'h3000, NOP, 32'h0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
            checks++; if (o.fpc !== e.fpc) begin errors++; $display("FAIL reset_fpc[%0d]: got %h expected %h", n, o.fpc, e.fpc); end
            checks++; if (o.dinstr !== e.dinstr) begin errors++; $display("FAIL reset_dinstr[%0d]: got %h expected %h", n, o.dinstr, e.dinstr); end
            checks++; if (o.dpc !== e.dpc) begin errors++; $display("FAIL reset_dpc[%0d]: got %h expected %h", n, o.dpc, e.dpc); end
            if (ADEL_ON) begin checks++; if (o.adel !== e.adel) begin errors++; $display("FAIL reset_adel[%0d]: got %b expected %b", n, o.adel, e.adel); end end
        end
    endtask

    task automatic test_sequential();
        obs_t e, o;
        int   n = 0;
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I0, 32'h3004, I0, 32'h3000, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I1, 32'h3008, I1, 32'h3004, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I2, 32'h300C, I2, 32'h3008, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I0, 32'h3010, I0, 32'h300C, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
            checks++; if (o.fpc !== e.fpc) begin errors++; $display("FAIL seq_fpc[%0d]: got %h expected %h", n, o.fpc, e.fpc); end
            checks++; if (o.dinstr !== e.dinstr) begin errors++; $display("FAIL seq_dinstr[%0d]: got %h expected %h", n, o.dinstr, e.dinstr); end
            checks++; if (o.dpc !== e.dpc) begin errors++; $display("FAIL seq_dpc[%0d]: got %h expected %h", n, o.dpc, e.dpc); end
        end
    endtask

    task automatic test_branch();
        obs_t e, o;
        int   n = 0;
        // backward taken branch at 0x3010
        drive_cycle(0, 0, 2'b00, 0, 32'h0, BEQ, 32'h3014, BEQ, 32'h3010, 0);
        drive_cycle(0, 0, 2'b01, 1, 32'h0, DS,  32'h3004, DS,  32'h3014, 0);
        // same branch not taken
        drive_cycle(0, 0, 2'b11, 0, 32'h3010, I0, 32'h3010, I0, 32'h3004, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, BEQ, 32'h3014, BEQ, 32'h3010, 0);
        drive_cycle(0, 0, 2'b01, 0, 32'h0, DS,  32'h3018, DS,  32'h3014, 0);
        // forward taken branch, +16 words
        drive_cycle(0, 0, 2'b00, 0, 32'h0, BEQF, 32'h301C, BEQF, 32'h3018, 0);
        drive_cycle(0, 0, 2'b01, 1, 32'h0, I1,   32'h305C, I1,   32'h301C, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
            checks++; if (o.fpc !== e.fpc) begin errors++; $display("FAIL branch_fpc[%0d]: got %h expected %h", n, o.fpc, e.fpc); end
            checks++; if (o.dinstr !== e.dinstr) begin errors++; $display("FAIL branch_dinstr[%0d]: got %h expected %h", n, o.dinstr, e.dinstr); end
            checks++; if (o.dpc !== e.dpc) begin errors++; $display("FAIL branch_dpc[%0d]: got %h expected %h", n, o.dpc, e.dpc); end
        end
    endtask

    task automatic test_jump();
        obs_t e, o;
        int   n = 0;
        drive_cycle(0, 0, 2'b11, 0, 32'h3020, I0, 32'h3020, I0, 32'h305C, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, JI,  32'h3024, JI,  32'h3020, 0);
        drive_cycle(0, 0, 2'b10, 0, 32'h0, DS,  32'h3100, DS,  32'h3024, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, JRI, 32'h3104, JRI, 32'h3100, 0);
        drive_cycle(0, 0, 2'b11, 0, 32'h3200, I2, 32'h3200, I2, 32'h3104, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
            checks++; if (o.fpc !== e.fpc) begin errors++; $display("FAIL jump_fpc[%0d]: got %h expected %h", n, o.fpc, e.fpc); end
            checks++; if (o.dinstr !== e.dinstr) begin errors++; $display("FAIL jump_dinstr[%0d]: got %h expected %h", n, o.dinstr, e.dinstr); end
            checks++; if (o.dpc !== e.dpc) begin errors++; $display("FAIL jump_dpc[%0d]: got %h expected %h", n, o.dpc, e.dpc); end
        end
    endtask

    task automatic test_stall();
        obs_t e, o;
        int   n = 0;
        drive_cycle(0, 0, 2'b00, 0, 32'h0, JRI, 32'h3204, JRI, 32'h3200, 0);
        drive_cycle(0, 1, 2'b11, 0, 32'h3300, I0, 32'h3204, JRI, 32'h3200, 0);
        drive_cycle(0, 1, 2'b11, 0, 32'h3300, I1, 32'h3204, JRI, 32'h3200, 0);
        drive_cycle(0, 1, 2'b11, 0, 32'h3400, I2, 32'h3204, JRI, 32'h3200, 0);
        drive_cycle(0, 0, 2'b11, 0, 32'h3400, DS, 32'h3400, DS,  32'h3204, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
            checks++; if (o.fpc !== e.fpc) begin errors++; $display("FAIL stall_fpc[%0d]: got %h expected %h", n, o.fpc, e.fpc); end
            checks++; if (o.dinstr !== e.dinstr) begin errors++; $display("FAIL stall_dinstr[%0d]: got %h expected %h", n, o.dinstr, e.dinstr); end
            checks++; if (o.dpc !== e.dpc) begin errors++; $display("FAIL stall_dpc[%0d]: got %h expected %h", n, o.dpc, e.dpc); end
            if (ADEL_ON) begin checks++; if (o.adel !== e.adel) begin errors++; $display("FAIL stall_adel[%0d]: got %b expected %b", n, o.adel, e.adel); end end
        end
    endtask

    task automatic test_wrap();
        obs_t e, o;
        int   n = 0;
        drive_cycle(0, 0, 2'b11, 0, 32'hFFFF_FFFC, I0, 32'hFFFF_FFFC, I0, 32'h3400, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I1, 32'h0000_0000, ADEL_ON ? NOP : I1, 32'hFFFF_FFFC, ADEL_ON);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I2, 32'h0000_0004, ADEL_ON ? NOP : I2, 32'h0000_0000, ADEL_ON);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
            checks++; if (o.fpc !== e.fpc) begin errors++; $display("FAIL wrap_fpc[%0d]: got %h expected %h", n, o.fpc, e.fpc); end
            checks++; if (o.dinstr !== e.dinstr) begin errors++; $display("FAIL wrap_dinstr[%0d]: got %h expected %h", n, o.dinstr, e.dinstr); end
            checks++; if (o.dpc !== e.dpc) begin errors++; $display("FAIL wrap_dpc[%0d]: got %h expected %h", n, o.dpc, e.dpc); end
            if (ADEL_ON) begin checks++; if (o.adel !== e.adel) begin errors++; $display("FAIL wrap_adel[%0d]: got %b expected %b", n, o.adel, e.adel); end end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        int   n = 0;
        drive_cycle(0, 0, 2'b11, 0, 32'h3010, BEQ, 32'h3010, ADEL_ON ? NOP : BEQ, 32'h0000_0004, ADEL_ON);
        drive_cycle(1, 1, 2'b01, 1, 32'h1234, I0,  32'h3000, NOP, 32'h0, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I0,     32'h3004, I0,  32'h3000, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
            checks++; if (o.fpc !== e.fpc) begin errors++; $display("FAIL rstmid_fpc[%0d]: got %h expected %h", n, o.fpc, e.fpc); end
            checks++; if (o.dinstr !== e.dinstr) begin errors++; $display("FAIL rstmid_dinstr[%0d]: got %h expected %h", n, o.dinstr, e.dinstr); end
            checks++; if (o.dpc !== e.dpc) begin errors++; $display("FAIL rstmid_dpc[%0d]: got %h expected %h", n, o.dpc, e.dpc); end
            if (ADEL_ON) begin checks++; if (o.adel !== e.adel) begin errors++; $display("FAIL rstmid_adel[%0d]: got %b expected %b", n, o.adel, e.adel); end end
        end
    endtask

`ifdef IFU_FD_ADEL_EN
    task automatic test_adel();
        obs_t e, o;
        int   n = 0;
        drive_cycle(0, 0, 2'b11, 0, 32'h3002, I1, 32'h3002, I1,  32'h3004, 0);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I2,    32'h3006, NOP, 32'h3002, 1);
        drive_cycle(0, 0, 2'b11, 0, 32'h7000, I0, 32'h7000, NOP, 32'h3006, 1);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I1,    32'h7004, NOP, 32'h7000, 1);
        drive_cycle(0, 0, 2'b11, 0, 32'h6FFC, I2, 32'h6FFC, NOP, 32'h7004, 1);
        drive_cycle(0, 0, 2'b00, 0, 32'h0, I0,    32'h7000, I0,  32'h6FFC, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
            checks++; if (o.fpc !== e.fpc) begin errors++; $display("FAIL adel_fpc[%0d]: got %h expected %h", n, o.fpc, e.fpc); end
            checks++; if (o.dinstr !== e.dinstr) begin errors++; $display("FAIL adel_dinstr[%0d]: got %h expected %h", n, o.dinstr, e.dinstr); end
            checks++; if (o.dpc !== e.dpc) begin errors++; $display("FAIL adel_dpc[%0d]: got %h expected %h", n, o.dpc, e.dpc); end
            checks++; if (o.adel !== e.adel) begin errors++; $display("FAIL adel_flag[%0d]: got %b expected %b", n, o.adel, e.adel); end
        end
    endtask
`endif

    initial begin
        reset             = 1'b1;
        bus.stall         = 1'b0;
        bus.D_npcOp       = 2'b00;
        bus.D_branchTaken = 1'b0;
        bus.D_rsData      = '0;
        bus.F_instr       = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_reset_mid();
`ifdef IFU_FD_ADEL_EN
        test_adel();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
